// File: rtl/keypad_pkg.sv
// Shared definitions for the 4x4 keypad entry block: FSM encoding, key codes,
// default timing parameters and the row/column to key-code map.
package keypad_pkg;

  typedef enum logic [1:0] {
    ST_SCAN     = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_HELD     = 2'd2,
    ST_RELEASE  = 2'd3
  } state_e;

  localparam int DEF_SCAN_DIV  = 50_000;
  localparam int DEF_DEB_TICKS = 8;

  localparam logic [3:0] KEY_STAR = 4'hE;
  localparam logic [3:0] KEY_HASH = 4'hF;

  // Rows 0-2 hold digits 1-9 left to right; column 3 holds A-D; row 3 is * 0 #.
  function automatic logic [3:0] key_lookup(input logic [1:0] row, input logic [1:0] col);
    logic [3:0] code;
    if (col == 2'd3) begin
      code = 4'hA + {2'b00, row};
    end else if (row == 2'd3) begin
      code = (col == 2'd0) ? KEY_STAR : (col == 2'd1) ? 4'h0 : KEY_HASH;
    end else begin
      code = ({2'b00, row} * 4'd3) + {2'b00, col} + 4'd1;
    end
    return code;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous level inputs; idles high to match
// the pulled-up keypad rows.
module sync_2ff #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] meta_q;
  logic [W-1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= '1;
      sync_q <= '1;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/keypad_entry.sv
// 4x4 matrix keypad scanner with debounce and a decimal entry accumulator
// that commits an 8-bit value on '#'.
module keypad_entry
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV  = DEF_SCAN_DIV,
  parameter int DEB_TICKS = DEF_DEB_TICKS
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] ROWS,
  output logic [3:0] COLS,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic [7:0] numero,
  output logic       enter,
  output logic       overflow
);

  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int DEB_W = $clog2(DEB_TICKS + 1);

  logic [3:0]       rows_sync;
  logic [DIV_W-1:0] div_q, div_d;
  logic             tick;
  state_e           state_q, state_d;
  logic [1:0]       col_q, col_d;
  logic [1:0]       row_q, row_d;
  logic [DEB_W-1:0] cnt_q, cnt_d;
  logic [3:0]       key_code_q, key_code_d;
  logic             key_valid_q, key_valid_d;
  logic [8:0]       acc_q, acc_d;
  logic [7:0]       numero_q, numero_d;
  logic             enter_q, enter_d;
  logic             ovf_q, ovf_d;
  logic             any_low;
  logic [1:0]       low_row;
  logic [11:0]      acc_next;

  sync_2ff #(.W(4)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (ROWS),
    .q_o   (rows_sync)
  );

  assign tick  = (div_q == DIV_W'(SCAN_DIV - 1));
  assign div_d = tick ? '0 : div_q + 1'b1;

  assign any_low = (rows_sync != 4'hF);

  always_comb begin
    low_row = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (!rows_sync[i]) low_row = 2'(i);
    end
  end

  always_comb begin
    state_d     = state_q;
    col_d       = col_q;
    row_d       = row_q;
    cnt_d       = cnt_q;
    key_code_d  = key_code_q;
    key_valid_d = 1'b0;
    if (tick) begin
      case (state_q)
        ST_SCAN: begin
          if (any_low) begin
            row_d   = low_row;
            cnt_d   = '0;
            state_d = ST_DEBOUNCE;
          end else begin
            col_d = col_q + 2'd1;
          end
        end
        ST_DEBOUNCE: begin
          if (!rows_sync[row_q]) begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_d == DEB_W'(DEB_TICKS)) begin
              state_d     = ST_HELD;
              key_valid_d = 1'b1;
              key_code_d  = key_lookup(row_q, col_q);
            end
          end else begin
            state_d = ST_SCAN;
          end
        end
        ST_HELD: begin
          if (!any_low) begin
            cnt_d   = '0;
            state_d = ST_RELEASE;
          end
        end
        ST_RELEASE: begin
          if (!any_low) begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_d == DEB_W'(DEB_TICKS)) state_d = ST_SCAN;
          end else begin
            state_d = ST_HELD;
          end
        end
        default: state_d = ST_SCAN;
      endcase
    end
  end

  // Entry logic acts on the registered key, one cycle behind key_valid.
  assign acc_next = ({3'b000, acc_q} * 12'd10) + {8'h00, key_code_q};

  always_comb begin
    acc_d    = acc_q;
    ovf_d    = ovf_q;
    numero_d = numero_q;
    enter_d  = 1'b0;
    if (key_valid_q) begin
      if (key_code_q <= 4'd9) begin
        if (acc_next <= 12'd255) acc_d = acc_next[8:0];
        else                     ovf_d = 1'b1;
      end else if (key_code_q == KEY_STAR) begin
        acc_d = '0;
        ovf_d = 1'b0;
      end else if (key_code_q == KEY_HASH) begin
        numero_d = acc_q[7:0];
        enter_d  = 1'b1;
        acc_d    = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q       <= '0;
      state_q     <= ST_SCAN;
      col_q       <= 2'd0;
      row_q       <= 2'd0;
      cnt_q       <= '0;
      key_code_q  <= 4'h0;
      key_valid_q <= 1'b0;
      acc_q       <= '0;
      numero_q    <= 8'h00;
      enter_q     <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      div_q       <= div_d;
      state_q     <= state_d;
      col_q       <= col_d;
      row_q       <= row_d;
      cnt_q       <= cnt_d;
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
      acc_q       <= acc_d;
      numero_q    <= numero_d;
      enter_q     <= enter_d;
      ovf_q       <= ovf_d;
    end
  end

  assign COLS      = ~(4'b0001 << col_q);
  assign key_code  = key_code_q;
  assign key_valid = key_valid_q;
  assign numero    = numero_q;
  assign enter     = enter_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_keypad_entry.sv
// Randomized scoreboard bench for keypad_entry: a keypad matrix model drives
// ROWS from COLS, and an entry model predicts key codes, commits and overflow.
module tb_keypad_entry;

  localparam int SD = 4;
  localparam int DT = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] rows_w;
  logic [3:0] cols_w;
  logic [3:0] key_code;
  logic       key_valid;
  logic [7:0] numero;
  logic       enter;
  logic       overflow;

  logic [15:0] pressed = '0;
  logic [3:0]  force_low = '0;

  int checks = 0;
  int errors = 0;

  logic [3:0] exp_key_q[$];
  int         exp_num_q[$];
  int         m_acc = 0;
  bit         m_ovf = 1'b0;

  // Index r*4+c
  logic [3:0] keymap [16] = '{4'h1, 4'h2, 4'h3, 4'hA,
                              4'h4, 4'h5, 4'h6, 4'hB,
                              4'h7, 4'h8, 4'h9, 4'hC,
                              4'hE, 4'h0, 4'hF, 4'hD};

  always #5 clk = ~clk;

  keypad_entry #(.SCAN_DIV(SD), .DEB_TICKS(DT)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ROWS      (rows_w),
    .COLS      (cols_w),
    .key_code  (key_code),
    .key_valid (key_valid),
    .numero    (numero),
    .enter     (enter),
    .overflow  (overflow)
  );

  always_comb begin
    rows_w = 4'hF;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (pressed[r*4+c] && !cols_w[c]) rows_w[r] = 1'b0;
      end
    end
    rows_w = rows_w & ~force_low;
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic model_key(input logic [3:0] k);
    exp_key_q.push_back(k);
    if (k <= 4'd9) begin
      if (m_acc * 10 + int'(k) <= 255) m_acc = m_acc * 10 + int'(k);
      else m_ovf = 1'b1;
    end else if (k == 4'hE) begin
      m_acc = 0;
      m_ovf = 1'b0;
    end else if (k == 4'hF) begin
      exp_num_q.push_back(m_acc);
      m_acc = 0;
    end
  endtask

  task automatic press_mask(input logic [15:0] mask, input logic [3:0] code,
                            input int hold_ticks, input int gap_ticks);
    model_key(code);
    pressed = mask;
    repeat (hold_ticks * SD) @(negedge clk);
    check("key_accepted_pending", exp_key_q.size(), 0);
    pressed = '0;
    repeat (gap_ticks * SD) @(negedge clk);
    check("overflow", int'(overflow), int'(m_ovf));
  endtask

  task automatic press_key(input int idx);
    press_mask(16'(1) << idx, keymap[idx], 12, 7);
  endtask

  task automatic monitor();
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (key_valid) begin
          if (exp_key_q.size() == 0) begin
            check("unexpected_key_valid", int'(key_code), -1);
          end else begin
            logic [3:0] e;
            e = exp_key_q.pop_front();
            $display("key_valid code=0x%0h expected=0x%0h", key_code, e);
            check("key_code", int'(key_code), int'(e));
          end
        end
        if (enter) begin
          if (exp_num_q.size() == 0) begin
            check("unexpected_enter", int'(numero), -1);
          end else begin
            int n;
            n = exp_num_q.pop_front();
            $display("enter numero=%0d expected=%0d", numero, n);
            check("numero", int'(numero), n);
          end
        end
      end
    end
  endtask

  initial begin
    logic [3:0] cols0;
    int         waited;

    fork
      monitor();
    join_none

    repeat (3) @(negedge clk);
    check("rst_cols", int'(cols_w), 'hE);
    check("rst_key_code", int'(key_code), 0);
    check("rst_key_valid", int'(key_valid), 0);
    check("rst_numero", int'(numero), 0);
    check("rst_enter", int'(enter), 0);
    check("rst_overflow", int'(overflow), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Single long press of 5
    press_mask(16'(1) << 5, 4'h5, 10, 8);
    // 1 2 8 # commits 128; a second # shows the accumulator was cleared
    press_key(12);
    press_key(0);
    press_key(1);
    press_key(9);
    press_key(14);
    press_key(14);
    // 2 5 6 overflows with acc held at 25; * clears everything
    press_key(1);
    press_key(5);
    press_key(6);
    press_key(14);
    press_key(1);
    press_key(5);
    press_key(6);
    press_key(12);
    press_key(14);

    // Row 0 glitch of two ticks must not register and scanning must resume
    force_low = 4'b0001;
    repeat (2 * SD) @(negedge clk);
    force_low = 4'b0000;
    cols0 = cols_w;
    waited = 0;
    while (cols_w == cols0 && waited < 6 * SD) begin
      @(negedge clk);
      waited++;
    end
    check("glitch_scan_resumes", int'(cols_w != cols0), 1);
    repeat (4 * SD) @(negedge clk);

    // 3 and 9 together in column 2: lowest row wins
    press_mask((16'(1) << 2) | (16'(1) << 10), 4'h3, 12, 7);

    // Randomized entry
    for (int i = 0; i < 24; i++) begin
      int idx;
      idx = int'($urandom_range(0, 15));
      press_mask(16'(1) << idx, keymap[idx], int'($urandom_range(11, 14)),
                 int'($urandom_range(6, 8)));
    end

    // Reset while key 7 is held
    model_key(4'h7);
    pressed = 16'(1) << 8;
    repeat (12 * SD) @(negedge clk);
    check("key7_accepted_pending", exp_key_q.size(), 0);
    rst_n = 1'b0;
    m_acc = 0;
    m_ovf = 1'b0;
    @(negedge clk);
    pressed = '0;
    repeat (2) @(negedge clk);
    check("midrst_cols", int'(cols_w), 'hE);
    check("midrst_key_code", int'(key_code), 0);
    check("midrst_key_valid", int'(key_valid), 0);
    check("midrst_numero", int'(numero), 0);
    check("midrst_enter", int'(enter), 0);
    check("midrst_overflow", int'(overflow), 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("postrst_cols", int'(cols_w), 'hE);
    repeat (10 * SD) @(negedge clk);
    press_key(14);

    check("key_queue_drained", exp_key_q.size(), 0);
    check("num_queue_drained", exp_num_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
